// File: rtl/scroll_pkg.sv
// Shared constants for the seven-segment scroll path: step direction, fill mode
// and the default step period.
package scroll_pkg;

  localparam logic DIR_LEFT    = 1'b0;
  localparam logic DIR_RIGHT   = 1'b1;
  localparam logic MODE_ROTATE = 1'b0;
  localparam logic MODE_SHIFT  = 1'b1;

  localparam int DEFAULT_PERIOD = 25_000_000;

endpackage

// File: rtl/scroll_timer.sv
// Step prescaler: counts 0..PERIOD-1 while enabled and pulses out_TICK during the
// terminal count. The counter is held at zero while disabled or cleared.
module scroll_timer
  import scroll_pkg::*;
#(
  parameter int PERIOD = DEFAULT_PERIOD
) (
  input  logic in_CLK,
  input  logic in_RST_N,
  input  logic in_EN,
  input  logic in_CLEAR,
  output logic out_TICK
);

  localparam int CW = $clog2(PERIOD);
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (in_CLEAR || !in_EN || (count_reg == LAST)) begin
      count_next = '0;
    end else begin
      count_next = count_reg + 1'b1;
    end
  end

  always_ff @(posedge in_CLK or negedge in_RST_N) begin
    if (!in_RST_N) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign out_TICK = in_EN && (count_reg == LAST);

endmodule

// File: rtl/scroll_reg.sv
// Digit-scrolling register: parallel load, then rotate/shift one digit per step
// (timer tick or manual request), with position tracking and wrap reporting.
module scroll_reg
  import scroll_pkg::*;
#(
  parameter int DIGITS  = 4,
  parameter int DIGIT_W = 4,
  parameter int PERIOD  = DEFAULT_PERIOD
) (
  input  logic                        in_CLK,
  input  logic                        in_RST_N,
  input  logic [DIGITS*DIGIT_W-1:0]   in_D,
  input  logic                        in_LOAD,
  input  logic                        in_EN,
  input  logic                        in_STEP,
  input  logic                        in_DIR,
  input  logic                        in_MODE,
  input  logic [DIGIT_W-1:0]          in_FILL,
  output logic [DIGITS*DIGIT_W-1:0]   out_Q,
  output logic [$clog2(DIGITS)-1:0]   out_POS,
  output logic                        out_STEP,
  output logic                        out_WRAP
);

  localparam int QW = DIGITS * DIGIT_W;
  localparam int PW = $clog2(DIGITS);
  localparam logic [PW-1:0] POS_LAST = PW'(DIGITS - 1);

  logic [QW-1:0] q_reg, q_next;
  logic [PW-1:0] pos_reg, pos_next;
  logic          step_reg, step_next;
  logic          wrap_reg, wrap_next;
  // Low for the first edge after reset release so nothing steps on that edge.
  logic          arm_reg;
  logic          tick;
  logic          step_cond;
  logic [QW-1:0] left_word, right_word;

  scroll_timer #(
    .PERIOD(PERIOD)
  ) u_timer (
    .in_CLK   (in_CLK),
    .in_RST_N (in_RST_N),
    .in_EN    (in_EN && arm_reg),
    .in_CLEAR (in_LOAD),
    .out_TICK (tick)
  );

  assign step_cond = arm_reg && (tick || in_STEP);

  // Digit 0 is the least-significant (rightmost) digit.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      if (gi == 0) begin : g_left_ls
        assign left_word[DIGIT_W-1:0] =
          (in_MODE == MODE_SHIFT) ? in_FILL : q_reg[QW-1 -: DIGIT_W];
      end else begin : g_left_mid
        assign left_word[gi*DIGIT_W +: DIGIT_W] = q_reg[(gi-1)*DIGIT_W +: DIGIT_W];
      end
      if (gi == DIGITS - 1) begin : g_right_ms
        assign right_word[QW-1 -: DIGIT_W] =
          (in_MODE == MODE_SHIFT) ? in_FILL : q_reg[DIGIT_W-1:0];
      end else begin : g_right_mid
        assign right_word[gi*DIGIT_W +: DIGIT_W] = q_reg[(gi+1)*DIGIT_W +: DIGIT_W];
      end
    end
  endgenerate

  always_comb begin
    q_next    = q_reg;
    pos_next  = pos_reg;
    step_next = 1'b0;
    wrap_next = 1'b0;
    if (in_LOAD) begin
      q_next   = in_D;
      pos_next = '0;
    end else if (step_cond) begin
      step_next = 1'b1;
      if (in_DIR == DIR_LEFT) begin
        q_next = left_word;
        if (pos_reg == POS_LAST) begin
          pos_next  = '0;
          wrap_next = 1'b1;
        end else begin
          pos_next = pos_reg + 1'b1;
        end
      end else begin
        q_next = right_word;
        if (pos_reg == '0) begin
          pos_next  = POS_LAST;
          wrap_next = 1'b1;
        end else begin
          pos_next = pos_reg - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge in_CLK or negedge in_RST_N) begin
    if (!in_RST_N) begin
      q_reg    <= '0;
      pos_reg  <= '0;
      step_reg <= 1'b0;
      wrap_reg <= 1'b0;
      arm_reg  <= 1'b0;
    end else begin
      q_reg    <= q_next;
      pos_reg  <= pos_next;
      step_reg <= step_next;
      wrap_reg <= wrap_next;
      arm_reg  <= 1'b1;
    end
  end

  assign out_Q    = q_reg;
  assign out_POS  = pos_reg;
  assign out_STEP = step_reg;
  assign out_WRAP = wrap_reg;

endmodule

// File: tb/tb_scroll_reg.sv
// Scoreboard bench for scroll_reg: a digit-queue reference model predicts each
// cycle's outputs, and a negedge monitor pops and compares them.
module tb_scroll_reg;
  import scroll_pkg::*;

  localparam int DIGITS  = 4;
  localparam int DIGIT_W = 4;
  localparam int PERIOD  = 4;
  localparam int QW      = DIGITS * DIGIT_W;
  localparam int PW      = $clog2(DIGITS);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [QW-1:0] d = '0;
  logic          load = 1'b0, en = 1'b0, step = 1'b0, dir = 1'b0, mode = 1'b0;
  logic [DIGIT_W-1:0] fill = '0;
  logic [QW-1:0] q;
  logic [PW-1:0] pos;
  logic          ostep, wrap;

  always #5 clk = ~clk;

  scroll_reg #(
    .DIGITS (DIGITS),
    .DIGIT_W(DIGIT_W),
    .PERIOD (PERIOD)
  ) dut (
    .in_CLK  (clk),
    .in_RST_N(rst_n),
    .in_D    (d),
    .in_LOAD (load),
    .in_EN   (en),
    .in_STEP (step),
    .in_DIR  (dir),
    .in_MODE (mode),
    .in_FILL (fill),
    .out_Q   (q),
    .out_POS (pos),
    .out_STEP(ostep),
    .out_WRAP(wrap)
  );

  typedef struct packed {
    logic [QW-1:0] q;
    logic [PW-1:0] pos;
    logic          st;
    logic          wr;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: digits as a queue, index 0 = leftmost (MS) digit.
  int m_dig[$];
  int m_pos;
  int m_elapsed;
  bit m_armed;

  // Observations collected by the directed tests.
  logic [QW-1:0] seen_q[$];
  int            seen_pos[$];
  int            seen_wraps;

  task automatic check(input string name, input logic [QW-1:0] act, input logic [QW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [QW-1:0] m_word();
    logic [QW-1:0] w = '0;
    foreach (m_dig[i]) w = (w << DIGIT_W) | QW'(m_dig[i]);
    return w;
  endfunction

  function automatic void model_reset();
    m_dig.delete();
    for (int i = 0; i < DIGITS; i++) m_dig.push_back(0);
    m_pos     = 0;
    m_elapsed = 0;
    m_armed   = 1'b0;
  endfunction

  // Predict the outputs after the next edge from the current inputs, then clock.
  task automatic cycle();
    exp_t e;
    bit   ten, tick, stp;
    int   dv;
    ten  = en && m_armed;
    tick = ten && (m_elapsed == PERIOD - 1);
    stp  = m_armed && (tick || step);
    e.st = 1'b0;
    e.wr = 1'b0;
    if (load) begin
      m_dig.delete();
      for (int i = DIGITS - 1; i >= 0; i--) m_dig.push_back(int'((d >> (i * DIGIT_W)) & 16'hF));
      m_pos = 0;
    end else if (stp) begin
      e.st = 1'b1;
      if (dir == DIR_LEFT) begin
        dv = m_dig.pop_front();
        m_dig.push_back((mode == MODE_SHIFT) ? int'(fill) : dv);
        m_pos = (m_pos + 1) % DIGITS;
        e.wr  = (m_pos == 0);
      end else begin
        dv = m_dig.pop_back();
        m_dig.push_front((mode == MODE_SHIFT) ? int'(fill) : dv);
        m_pos = (m_pos + DIGITS - 1) % DIGITS;
        e.wr  = (m_pos == DIGITS - 1);
      end
    end
    m_elapsed = (load || !ten) ? 0 : (m_elapsed + 1) % PERIOD;
    m_armed   = 1'b1;
    e.q   = m_word();
    e.pos = PW'(m_pos);
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) begin
      cycle();
      if (ostep) begin
        seen_q.push_back(q);
        seen_pos.push_back(int'(pos));
        if (wrap) seen_wraps++;
      end
    end
  endtask

  task automatic clear_seen();
    seen_q.delete();
    seen_pos.delete();
    seen_wraps = 0;
  endtask

  // Reset asserted mid-cycle, checked before any edge, held across one edge.
  task automatic do_reset(input string tag);
    #2 rst_n = 1'b0;
    sb.delete();
    model_reset();
    #1;
    check({tag, "_rst_q"}, q, '0);
    check({tag, "_rst_pos"}, QW'(pos), '0);
    check({tag, "_rst_pulses"}, QW'({ostep, wrap}), '0);
    @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("q", q, e.q);
      check("pos", QW'(pos), QW'(e.pos));
      check("step", QW'(ostep), QW'(e.st));
      check("wrap", QW'(wrap), QW'(e.wr));
      if (ostep) $display("step q=%h pos=%0d wrap=%b", q, pos, wrap);
    end
  end

  initial begin
    int lat;
    model_reset();
    clear_seen();

    // 1: reset state, then idle with EN low
    #23;
    check("t1_rst_q", q, '0);
    check("t1_rst_pulses", QW'({ostep, wrap, pos}), '0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    run_n(10);
    check("t1_idle_q", q, '0);

    // 2: left rotate
    d = 16'h1234; load = 1'b1; dir = DIR_LEFT; mode = MODE_ROTATE;
    cycle();
    load = 1'b0; en = 1'b1;
    clear_seen();
    run_n(16);
    check("t2_nsteps", QW'(seen_q.size()), 16'd4);
    if (seen_q.size() == 4) begin
      check("t2_s0", seen_q[0], 16'h2341);
      check("t2_s1", seen_q[1], 16'h3412);
      check("t2_s2", seen_q[2], 16'h4123);
      check("t2_s3", seen_q[3], 16'h1234);
      check("t2_pos3", QW'(seen_pos[3]), 16'd0);
    end
    check("t2_wraps", QW'(seen_wraps), 16'd1);

    // 3: right shift with fill
    en = 1'b0; d = 16'h1234; load = 1'b1; dir = DIR_RIGHT; mode = MODE_SHIFT; fill = 4'hF;
    cycle();
    load = 1'b0; en = 1'b1;
    clear_seen();
    run_n(16);
    check("t3_nsteps", QW'(seen_q.size()), 16'd4);
    if (seen_q.size() == 4) begin
      check("t3_s0", seen_q[0], 16'hF123);
      check("t3_pos0", QW'(seen_pos[0]), 16'd3);
      check("t3_s1", seen_q[1], 16'hFF12);
      check("t3_s3", seen_q[3], 16'hFFFF);
    end
    check("t3_wraps", QW'(seen_wraps), 16'd1);

    // 4: load beats a coincident terminal count and manual step
    dir = DIR_LEFT; mode = MODE_ROTATE;
    run_n(3);
    d = 16'hABCD; load = 1'b1; step = 1'b1;
    cycle();
    load = 1'b0; step = 1'b0;
    check("t4_q", q, 16'hABCD);
    check("t4_pos", QW'(pos), '0);
    check("t4_nostep", QW'(ostep), '0);
    lat = -1;
    for (int i = 1; i <= 8 && lat < 0; i++) begin
      cycle();
      if (ostep) lat = i;
    end
    check("t4_latency", QW'(lat), 16'd4);
    check("t4_step_q", q, 16'hBCDA);

    // 5: manual step, then manual step coincident with terminal count
    en = 1'b0; d = 16'h1234; load = 1'b1;
    cycle();
    load = 1'b0; step = 1'b1;
    cycle();
    step = 1'b0;
    check("t5_manual_q", q, 16'h2341);
    run_n(3);
    check("t5_hold_q", q, 16'h2341);
    en = 1'b1;
    run_n(3);
    step = 1'b1;
    cycle();
    step = 1'b0;
    check("t5_coinc_q", q, 16'h3412);
    check("t5_coinc_pos", QW'(pos), 16'd2);
    cycle();
    check("t5_single_q", q, 16'h3412);
    check("t5_single_step", QW'(ostep), '0);

    // 6: reset two cycles into a period, then first step after release
    run_n(2);
    do_reset("t6");
    lat = -1;
    for (int i = 0; i <= 8 && lat < 0; i++) begin
      cycle();
      if (ostep) lat = i;
    end
    check("t6_latency", QW'(lat), 16'd4);

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      load = ($urandom_range(0, 15) == 0);
      en   = ($urandom_range(0, 7) != 0);
      step = ($urandom_range(0, 5) == 0);
      dir  = 1'($urandom);
      mode = 1'($urandom);
      fill = DIGIT_W'($urandom);
      d    = QW'($urandom);
      if ($urandom_range(0, 149) == 0) do_reset("rnd");
      cycle();
    end
    load = 1'b0; en = 1'b0; step = 1'b0;
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/scroll_reg.md
# scroll_reg

Parametrised digit-scrolling register for the seven-segment scroll path. It holds `DIGITS` digits of `DIGIT_W` bits and parallel-loads a message word. An internal prescaler then rotates or shifts the word one digit per step, left or right, with optional manual stepping. It replaces the fixed 16-bit enable register that feeds the display mux, and adds position tracking and wrap reporting.

## Interface
Parameters:
- `DIGITS`, 4, number of digits held (≥2)
- `DIGIT_W`, 4, bits per digit
- `PERIOD`, 25_000_000, clock cycles between automatic scroll steps (≥2)

Ports:
- `in_CLK` input 1: the single clock; all state updates on the rising edge
- `in_RST_N` input 1: reset, asynchronous and active-low
- `in_D` input DIGITS*DIGIT_W: parallel load word; most-significant digit is the leftmost display digit
- `in_LOAD` input 1: load `in_D` this cycle
- `in_EN` input 1: automatic scrolling enable
- `in_STEP` input 1: manual single-step request, one step per cycle held high
- `in_DIR` input 1: 0 = left (toward MS digit), 1 = right
- `in_MODE` input 1: 0 = rotate, 1 = shift with fill
- `in_FILL` input DIGIT_W: digit inserted in shift mode
- `out_Q` output DIGITS*DIGIT_W: current register contents
- `out_POS` output $clog2(DIGITS): scroll offset since last load, modulo DIGITS
- `out_STEP` output 1: one-cycle pulse, high in the cycle `out_Q` shows a new step
- `out_WRAP` output 1: one-cycle pulse coincident with `out_STEP` when `out_POS` wraps

## Operation
- **Reset:** `out_Q` = 0, `out_POS` = 0, `out_STEP` = 0, `out_WRAP` = 0, and the timer is 0.
- **Timer:**
  - While `in_EN` = 1, it counts 0..PERIOD-1.
  - The terminal count (PERIOD-1) raises the step condition and the timer returns to 0.
  - While `in_EN` = 0, the timer is held at 0.
- **Step condition:** (timer terminal AND `in_EN`) OR `in_STEP`. If both sources are true in one cycle, exactly one step is taken.
- **Priority:** `in_LOAD` overrides a step.
  - Load writes `in_D` to `out_Q`, clears `out_POS` and clears the timer.
  - Load suppresses `out_STEP` and `out_WRAP` for that cycle.
- **Left step:**
  - Rotate: the MS digit moves to the LS position.
  - Shift: the MS digit is discarded and `in_FILL` enters at the LS position.
  - `out_POS` increments; DIGITS-1 → 0 raises `out_WRAP`.
- **Right step:**
  - Rotate: the LS digit moves to the MS position.
  - Shift: the LS digit is discarded and `in_FILL` enters at the MS position.
  - `out_POS` decrements; 0 → DIGITS-1 raises `out_WRAP`.
- `out_POS` is tracked identically in shift mode, as a step count only.
- `in_DIR`, `in_MODE` and `in_FILL` are sampled in the step cycle only. Changing them between steps is legal and takes effect at the next step.
- With no load and no step, `out_Q` and `out_POS` hold.

## Timing
- All outputs are registered.
- A step condition true in cycle n gives the new `out_Q`/`out_POS` and `out_STEP` = 1 in cycle n+1.
- A load in cycle n gives `out_Q` = `in_D` in cycle n+1.
- With `in_EN` held high from a load in cycle n, the first automatic step is visible in cycle n+PERIOD+1, and subsequent steps follow every PERIOD cycles.
- Raising `in_EN` after idle: the first step is visible PERIOD cycles later.
- Deasserting `in_RST_N` mid-count or mid-step clears all state immediately, without waiting for a clock edge. No step is produced on the first edge after release.

## Structure
- Shared package `scroll_pkg`:
  - `DIR_LEFT` = 1'b0, `DIR_RIGHT` = 1'b1
  - `MODE_ROTATE` = 1'b0, `MODE_SHIFT` = 1'b1
  - default `PERIOD`
- Sub-module `scroll_timer`:
  - Parametrised by `PERIOD`.
  - Inputs `in_CLK`, `in_RST_N`, `in_EN`, clear.
  - Output `out_TICK`, the terminal-count pulse.
  - Counter width is $clog2(PERIOD).
- The digit datapath and `out_POS` live in `scroll_reg`.

## Test plan
Bench parameters: DIGITS=4, DIGIT_W=4, PERIOD=4.
1. **Reset state:** assert `in_RST_N` = 0 asynchronously mid-cycle → `out_Q` = 16'h0000, `out_POS` = 0, no pulses. Release, keep `in_EN` = 0 for 10 cycles → no change.
2. **Left rotate:** load 16'h1234, `in_EN` = 1, DIR = left, MODE = rotate → `out_Q` steps every 4 cycles: 2341 (POS 1), 3412 (2), 4123 (3), 1234 (POS 0, `out_WRAP` = 1 on this step only).
3. **Right shift with fill:** load 16'h1234, DIR = right, MODE = shift, FILL = F → F123 (POS 3, WRAP = 1), FF12 (POS 2), FFF1, FFFF.
4. **Load beats step:** `in_LOAD` = 1 with `in_D` = 16'hABCD in the same cycle as the timer terminal and `in_STEP` → `out_Q` = ABCD, POS 0, `out_STEP` = 0. The next step is visible exactly 4 cycles later.
5. **Manual and coincident steps:** `in_EN` = 0, one-cycle `in_STEP` on 16'h1234 left rotate → single step to 2341. Then `in_EN` = 1 with `in_STEP` coincident with the terminal count → exactly one step (3412), not two.
6. **Reset mid-operation:** drop `in_RST_N` two cycles into a period after POS 2 → all outputs 0 immediately. After release with `in_EN` = 1, the first step is visible exactly 4 cycles after the first active edge.
